instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 15 +
 rtl/instr_fetch_unit_pc_reg.sv | 28 ++
 rtl/instr_fetch_unit.sv | 116 +++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: default constants and
// the 2-bit fetch-state encoding.
package instr_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10,
        ST_DROP  = 2'b11
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: async active-low reset, load enable and
// next-PC select between sequential PC+4 and a word-aligned redirect target.
module instr_fetch_unit_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'd4;
    assign pc_next  = sel_target ? (target & 32'hFFFF_FFFC) : pc_plus4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one-outstanding-request memory fetch with stall,
// redirect and discard of responses that belong to a squashed fetch.
//
//   state | meaning
//   FETCH | request driven at PC, waiting for grant
//   WAIT  | granted, awaiting response data
//   VALID | fetched instruction held for decode
//   DROP  | response still outstanding for a redirected fetch, discard it
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        FetchBusyF
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  instr_q;
    logic         pc_load;
    logic         pc_sel_target;
    logic         capture;

    instr_fetch_unit_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pc_load),
        .sel_target (pc_sel_target),
        .target     (PCTargetE),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q <= imem_rdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_load       = PCSrcE;
        pc_sel_target = PCSrcE;
        capture       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_gnt) begin
                    state_d = PCSrcE ? ST_DROP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (PCSrcE) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_VALID;
                        capture = 1'b1;
                    end
                end else if (PCSrcE) begin
                    state_d = ST_DROP;
                end
            end
            ST_VALID: begin
                if (PCSrcE) begin
                    state_d = ST_FETCH;
                end else if (!StallF) begin
                    state_d = ST_FETCH;
                    pc_load = 1'b1;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets the PC; the stale response must still be consumed.
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_req    = (state_q == ST_FETCH) && reset_n;
    assign imem_addr   = pc;
    assign PCF         = pc;
    assign PCPlus4F    = pc_plus4;
    assign InstrValidF = (state_q == ST_VALID);
    assign InstrF      = InstrValidF ? instr_q : NOP_INSTR;
    assign FetchBusyF  = !InstrValidF;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized traffic against a flag-based reference model.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset_n;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] PCF,       PCF2;
    logic [31:0] PCPlus4F,  PCPlus4F2;
    logic [31:0] InstrF,    InstrF2;
    logic        InstrValidF, InstrValidF2;
    logic        FetchBusyF,  FetchBusyF2;

    instr_fetch_unit u_dut (
        .clk(clk), .reset_n(reset_n), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCF(PCF), .PCPlus4F(PCPlus4F), .InstrF(InstrF),
        .InstrValidF(InstrValidF), .FetchBusyF(FetchBusyF)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clk(clk), .reset_n(reset_n), .StallF(StallF), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .PCF(PCF2), .PCPlus4F(PCPlus4F2), .InstrF(InstrF2),
        .InstrValidF(InstrValidF2), .FetchBusyF(FetchBusyF2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: PC, whether a request is outstanding, whether that
    // response is to be thrown away, and whether an instruction is held.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_discard;
    bit          m_held;
    logic [31:0] m_instr;

    int          resp_cnt;
    bit          use_fixed;
    logic [31:0] fixed_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_held    = 1'b0;
        m_instr   = NOP;
        resp_cnt  = 0;
    endtask

    task automatic step(input bit st, input bit rd, input logic [31:0] tg,
                        input bit g, input int dly, input bit spur);
        bit          rv;
        bit          exp_req;
        logic [31:0] rdat;
        @(negedge clk);
        rv   = 1'b0;
        rdat = use_fixed ? fixed_rdata : $urandom;
        if (resp_cnt == 1) rv = 1'b1;
        if (resp_cnt > 0) resp_cnt--;
        else if (spur) rv = 1'b1;

        exp_req = !m_held && !m_busy;
        chk("imem_req",    {31'b0, imem_req},    {31'b0, exp_req});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("PCF",         PCF,                  m_pc);
        chk("PCPlus4F",    PCPlus4F,             m_pc + 32'd4);
        chk("InstrF",      InstrF,               m_held ? m_instr : NOP);
        chk("InstrValidF", {31'b0, InstrValidF}, {31'b0, m_held});
        chk("FetchBusyF",  {31'b0, FetchBusyF},  {31'b0, !m_held});

        StallF      = st;
        PCSrcE      = rd;
        PCTargetE   = tg;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rdat;

        if (exp_req && g) resp_cnt = dly;

        if (m_held) begin
            if (rd)       begin m_pc = tg & 32'hFFFF_FFFC; m_held = 1'b0; end
            else if (!st) begin m_pc = m_pc + 32'd4;       m_held = 1'b0; end
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 1'b0;
                if (!m_discard && !rd) begin
                    m_held  = 1'b1;
                    m_instr = rdat;
                end
                m_discard = 1'b0;
            end else if (rd) begin
                m_discard = 1'b1;
            end
            if (rd) m_pc = tg & 32'hFFFF_FFFC;
        end else begin
            if (g) begin
                m_busy    = 1'b1;
                m_discard = rd;
            end
            if (rd) m_pc = tg & 32'hFFFF_FFFC;
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        #2;
        reset_n     = 1'b0;
        StallF      = 1'b0;
        PCSrcE      = 1'b0;
        PCTargetE   = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        if (check) begin
            chk("rst_req",   {31'b0, imem_req},    32'h0);
            chk("rst_PCF",   PCF,                  32'h0);
            chk("rst_InstrF", InstrF,              NOP);
            chk("rst_valid", {31'b0, InstrValidF}, 32'h0);
            chk("rst_PCF_wrap", PCF2,              32'hFFFF_FFFC);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n   = 1'b0;
        use_fixed = 1'b0;
        fixed_rdata = 32'h0;
        model_reset();
        do_reset(1'b1);

        // First request right after reset release, minimum-latency response.
        #1;
        chk("first_req",  {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr,         32'h0);
        use_fixed   = 1'b1;
        fixed_rdata = 32'h0050_0093;
        step(0, 0, 32'h0, 1, 1, 0);
        step(0, 0, 32'h0, 0, 1, 0);
        after_edge();
        chk("lat_valid",  {31'b0, InstrValidF}, 32'h1);
        chk("lat_PCF",    PCF,                  32'h0);
        chk("lat_PCP4",   PCPlus4F,             32'h4);
        chk("lat_InstrF", InstrF,               32'h0050_0093);
        chk("wrap_PCP4",  PCPlus4F2,            32'h0);
        chk("wrap_valid", {31'b0, InstrValidF2}, 32'h1);

        // Stall held for three cycles, then released.
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 32'h0, 1, 1, 0);
            after_edge();
            chk("stall_req",    {31'b0, imem_req}, 32'h0);
            chk("stall_InstrF", InstrF,            32'h0050_0093);
            chk("stall_PCF",    PCF,               32'h0);
        end
        step(0, 0, 32'h0, 0, 1, 0);
        after_edge();
        chk("rel_req",  {31'b0, imem_req}, 32'h1);
        chk("rel_addr", imem_addr,         32'h4);
        chk("wrap_next_addr", imem_addr2,  32'h0);
        use_fixed = 1'b0;

        // Redirect while waiting: response must be dropped.
        step(0, 0, 32'h0, 1, 3, 0);
        step(0, 1, 32'h0000_0102, 0, 1, 0);
        after_edge();
        chk("drop_req",   {31'b0, imem_req},    32'h0);
        chk("drop_PCF",   PCF,                  32'h0000_0100);
        chk("drop_valid", {31'b0, InstrValidF}, 32'h0);
        step(0, 0, 32'h0, 1, 1, 0);
        after_edge();
        chk("drop_hold_valid", {31'b0, InstrValidF}, 32'h0);
        chk("drop_hold_req",   {31'b0, imem_req},    32'h0);
        step(0, 0, 32'h0, 0, 1, 0);
        after_edge();
        chk("post_drop_req",   {31'b0, imem_req},    32'h1);
        chk("post_drop_addr",  imem_addr,            32'h0000_0100);
        chk("post_drop_valid", {31'b0, InstrValidF}, 32'h0);

        // Redirect and stall together in VALID.
        step(0, 0, 32'h0, 1, 1, 0);
        step(0, 0, 32'h0, 0, 1, 0);
        step(1, 1, 32'h0000_0200, 0, 1, 0);
        after_edge();
        chk("rs_req",   {31'b0, imem_req},    32'h1);
        chk("rs_addr",  imem_addr,            32'h0000_0200);
        chk("rs_valid", {31'b0, InstrValidF}, 32'h0);

        // Reset asserted while a request is in WAIT.
        step(0, 0, 32'h0, 1, 2, 0);
        do_reset(1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(1'b1);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(1, 3),
                 $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
